// File: rtl/coco_keymatrix.sv
// PS/2-to-CoCo keyboard matrix: 7x8 key matrix with registered active-low row data.
// Optional `KEYMATRIX_DRAGON_EN` adds the Dragon row remap and clear-on-layout-change.
module coco_keymatrix #(
  parameter int unsigned HOLD_CYCLES = 2863600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        dragon,
  input  logic [7:0]  col_strobe,
  input  logic [1:0]  fire,
  output logic [6:0]  row_out,
  output logic        caps_busy
);

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCombo, StRelease} seq_state_e;

  logic [10:0]      key_q;
  logic             key_prev_q;
  logic [6:0][7:0]  mat_q, mat_d, synth, eff;
  seq_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [6:0]       row_d, hit_coco, hit_phys;
  logic             key_ev, caps_make, dragon_chg;
  logic [6:0]       key_loc;

  // {valid, row[2:0], col[2:0]}
  function automatic logic [6:0] loc(input logic [2:0] r, input logic [2:0] c);
    return {1'b1, r, c};
  endfunction

  function automatic logic [6:0] map_key(input logic [8:0] k);
    logic [6:0] m;
    m = '0;
    case (k)
      9'h01C: m = loc(3'd0, 3'd1);  9'h032: m = loc(3'd0, 3'd2);  9'h021: m = loc(3'd0, 3'd3);
      9'h023: m = loc(3'd0, 3'd4);  9'h024: m = loc(3'd0, 3'd5);  9'h02B: m = loc(3'd0, 3'd6);
      9'h034: m = loc(3'd0, 3'd7);
      9'h033: m = loc(3'd1, 3'd0);  9'h043: m = loc(3'd1, 3'd1);  9'h03B: m = loc(3'd1, 3'd2);
      9'h042: m = loc(3'd1, 3'd3);  9'h04B: m = loc(3'd1, 3'd4);  9'h03A: m = loc(3'd1, 3'd5);
      9'h031: m = loc(3'd1, 3'd6);  9'h044: m = loc(3'd1, 3'd7);
      9'h04D: m = loc(3'd2, 3'd0);  9'h015: m = loc(3'd2, 3'd1);  9'h02D: m = loc(3'd2, 3'd2);
      9'h01B: m = loc(3'd2, 3'd3);  9'h02C: m = loc(3'd2, 3'd4);  9'h03C: m = loc(3'd2, 3'd5);
      9'h02A: m = loc(3'd2, 3'd6);  9'h01D: m = loc(3'd2, 3'd7);
      9'h022: m = loc(3'd3, 3'd0);  9'h035: m = loc(3'd3, 3'd1);  9'h01A: m = loc(3'd3, 3'd2);
      9'h175: m = loc(3'd3, 3'd3);  9'h172: m = loc(3'd3, 3'd4);  9'h16B: m = loc(3'd3, 3'd5);
      9'h066: m = loc(3'd3, 3'd5);  9'h174: m = loc(3'd3, 3'd6);  9'h029: m = loc(3'd3, 3'd7);
      9'h045: m = loc(3'd4, 3'd0);  9'h016: m = loc(3'd4, 3'd1);  9'h01E: m = loc(3'd4, 3'd2);
      9'h026: m = loc(3'd4, 3'd3);  9'h025: m = loc(3'd4, 3'd4);  9'h02E: m = loc(3'd4, 3'd5);
      9'h036: m = loc(3'd4, 3'd6);  9'h03D: m = loc(3'd4, 3'd7);
      9'h03E: m = loc(3'd5, 3'd0);  9'h046: m = loc(3'd5, 3'd1);
      9'h05A: m = loc(3'd6, 3'd0);  9'h16C: m = loc(3'd6, 3'd1);  9'h076: m = loc(3'd6, 3'd2);
      9'h012: m = loc(3'd6, 3'd7);  9'h059: m = loc(3'd6, 3'd7);
      default: m = '0;
    endcase
    return m;
  endfunction

`ifdef KEYMATRIX_DRAGON_EN
  logic dragon_q, dragon_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dragon_q      <= 1'b0;
      dragon_prev_q <= 1'b0;
    end else begin
      dragon_q      <= dragon;
      dragon_prev_q <= dragon_q;
    end
  end

  assign dragon_chg = dragon_q ^ dragon_prev_q;
`else
  logic unused_dragon;
  assign unused_dragon = dragon;
  assign dragon_chg    = 1'b0;
`endif

  assign key_ev    = key_q[10] ^ key_prev_q;
  assign key_loc   = map_key(key_q[8:0]);
  assign caps_make = key_ev && key_q[9] && (key_q[8:0] == 9'h058);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q      <= '0;
      key_prev_q <= 1'b0;
      mat_q      <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      row_out    <= 7'h7F;
    end else begin
      key_q      <= ps2_key;
      key_prev_q <= key_q[10];
      mat_q      <= mat_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_out    <= row_d;
    end
  end

  // A layout change takes priority over a coincident key event.
  always_comb begin
    mat_d = mat_q;
    if (dragon_chg) begin
      mat_d = '0;
    end else if (key_ev && key_loc[6]) begin
      mat_d[key_loc[5:3]][key_loc[2:0]] = key_q[9];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (caps_make) begin
          state_d = StShift;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          unique case (state_q)
            StShift: state_d = StCombo;
            StCombo: state_d = StRelease;
            default: state_d = StIdle;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    synth     = '0;
    caps_busy = (state_q != StIdle);
    unique case (state_q)
      StShift:   synth[6][7] = 1'b1;
      StCombo: begin
        synth[6][7] = 1'b1;
        synth[4][0] = 1'b1;
      end
      StRelease: synth[6][7] = 1'b1;
      default:   synth = '0;
    endcase
  end

  assign eff = mat_q | synth;

  always_comb begin
    for (int r = 0; r < 7; r++) begin
      hit_coco[r] = |(eff[r] & ~col_strobe);
    end
    hit_phys = hit_coco;
`ifdef KEYMATRIX_DRAGON_EN
    // CoCo row r lands on physical row (r+2) mod 6; row 6 stays put.
    if (dragon) begin
      hit_phys = {hit_coco[6], hit_coco[3:0], hit_coco[5:4]};
    end
`endif
    row_d = ~hit_phys & ~{5'b0, fire};
  end

endmodule

// File: tb/tb_coco_keymatrix.sv
// Self-checking bench for coco_keymatrix: directed scenarios plus randomized key traffic
// compared against a key-state table model.
module tb_coco_keymatrix;

  localparam int unsigned Hold = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        dragon;
  logic [7:0]  col_strobe;
  logic [1:0]  fire;
  logic [6:0]  row_out;
  logic        caps_busy;

  int n_pass = 0;
  int n_total = 0;

  logic     tog = 1'b0;
  bit       mdl [7][8];
  logic [8:0] kcode [$];
  int         krow [$];
  int         kcol [$];

  coco_keymatrix #(.HOLD_CYCLES(Hold)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .dragon     (dragon),
    .col_strobe (col_strobe),
    .fire       (fire),
    .row_out    (row_out),
    .caps_busy  (caps_busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_key(input logic [8:0] k, input int r, input int c);
    kcode.push_back(k);
    krow.push_back(r);
    kcol.push_back(c);
  endtask

  function automatic int find_key(input logic [8:0] k);
    for (int i = 0; i < kcode.size(); i++) if (kcode[i] == k) return i;
    return -1;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 7; r++) for (int c = 0; c < 8; c++) mdl[r][c] = 1'b0;
  endtask

  task automatic send_key(input logic make, input logic ext, input logic [7:0] code);
    int idx;
    tog = ~tog;
    ps2_key = {tog, make, ext, code};
    idx = find_key({ext, code});
    if (idx >= 0) mdl[krow[idx]][kcol[idx]] = make;
  endtask

  // Expected physical rows from the held-key table.
  function automatic logic [6:0] exp_row(input logic [7:0] col, input logic [1:0] fr,
                                         input logic drg);
    logic [6:0] e;
    for (int p = 0; p < 7; p++) begin
      int src;
      bit any;
      src = (drg && p < 6) ? (p + 4) % 6 : p;
      any = 0;
      for (int c = 0; c < 8; c++) if (mdl[src][c] && !col[c]) any = 1;
      e[p] = !(any || (p < 2 && fr[p] == 1'b1));
    end
    return e;
  endfunction

  task automatic build_table();
    logic [7:0] r0 [7];
    logic [7:0] r1 [8];
    logic [7:0] r2 [8];
    logic [7:0] r4 [8];
    r0 = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34};
    r1 = '{8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44};
    r2 = '{8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D};
    r4 = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};
    for (int i = 0; i < 7; i++) add_key({1'b0, r0[i]}, 0, i + 1);
    for (int i = 0; i < 8; i++) add_key({1'b0, r1[i]}, 1, i);
    for (int i = 0; i < 8; i++) add_key({1'b0, r2[i]}, 2, i);
    for (int i = 0; i < 8; i++) add_key({1'b0, r4[i]}, 4, i);
    add_key(9'h022, 3, 0); add_key(9'h035, 3, 1); add_key(9'h01A, 3, 2);
    add_key(9'h175, 3, 3); add_key(9'h172, 3, 4); add_key(9'h16B, 3, 5);
    add_key(9'h066, 3, 5); add_key(9'h174, 3, 6); add_key(9'h029, 3, 7);
    add_key(9'h03E, 5, 0); add_key(9'h046, 5, 1);
    add_key(9'h05A, 6, 0); add_key(9'h16C, 6, 1); add_key(9'h076, 6, 2);
    add_key(9'h012, 6, 7); add_key(9'h059, 6, 7);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ps2_key = '0;
    dragon = 1'b0;
    col_strobe = 8'hFD;
    fire = 2'b00;
    clear_model();
    tick(3);
    n_total++;
    if (row_out !== 7'h7F) $display("FAIL reset_row: got %h want 7f", row_out);
    else n_pass++;
    n_total++;
    if (caps_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", caps_busy);
    else n_pass++;
    reset = 1'b1;
    tick(3);
    n_total++;
    if (row_out !== 7'h7F) $display("FAIL post_reset_row: got %h want 7f", row_out);
    else n_pass++;
  endtask

  task automatic test_key_a();
    col_strobe = 8'hFD;
    tick(2);
    send_key(1'b1, 1'b0, 8'h1C);
    tick(2);
    n_total++;
    if (row_out !== 7'h7F) $display("FAIL a_latency2: got %h want 7f", row_out);
    else n_pass++;
    tick(1);
    n_total++;
    if (row_out !== 7'h7E) $display("FAIL a_make: got %h want 7e", row_out);
    else n_pass++;
    send_key(1'b1, 1'b0, 8'h1C);  // repeated make of a held key
    tick(3);
    n_total++;
    if (row_out !== 7'h7E) $display("FAIL a_repeat: got %h want 7e", row_out);
    else n_pass++;
    send_key(1'b0, 1'b0, 8'h1C);
    tick(3);
    n_total++;
    if (row_out !== 7'h7F) $display("FAIL a_break: got %h want 7f", row_out);
    else n_pass++;
  endtask

  task automatic test_up_arrow();
    col_strobe = 8'hF7;
    send_key(1'b1, 1'b1, 8'h75);
    tick(3);
    n_total++;
    if (row_out !== 7'h77) $display("FAIL up_coco: got %h want 77", row_out);
    else n_pass++;
    send_key(1'b0, 1'b1, 8'h75);
    tick(3);
`ifdef KEYMATRIX_DRAGON_EN
    dragon = 1'b1;
    tick(4);
    send_key(1'b1, 1'b1, 8'h75);
    tick(3);
    n_total++;
    if (row_out !== 7'h5F) $display("FAIL up_dragon: got %h want 5f", row_out);
    else n_pass++;
    send_key(1'b0, 1'b1, 8'h75);
    dragon = 1'b0;
    tick(4);
    clear_model();
`endif
  endtask

  task automatic caps_run(input logic [7:0] col, input int lo, input int hi,
                          input logic [6:0] low_val);
    logic [6:0] er;
    logic       eb;
    col_strobe = col;
    tick(2);
    send_key(1'b1, 1'b0, 8'h58);
    tick(1);
    for (int n = 1; n <= 16; n++) begin
      eb = (n >= 2 && n <= 13);
      er = (n >= lo && n <= hi) ? low_val : 7'h7F;
      n_total++;
      if (row_out !== er) $display("FAIL caps_row_n%0d: got %h want %h", n, row_out, er);
      else n_pass++;
      n_total++;
      if (caps_busy !== eb) $display("FAIL caps_busy_n%0d: got %b want %b", n, caps_busy, eb);
      else n_pass++;
      if (n == 4) send_key(1'b0, 1'b0, 8'h58);
      if (n == 6) send_key(1'b1, 1'b0, 8'h58);
      tick(1);
    end
  endtask

  task automatic test_caps();
    caps_run(8'h7F, 3, 14, 7'h3F);
    caps_run(8'hFE, 7, 10, 7'h6F);
  endtask

  task automatic test_fire();
    fire = 2'b01;
    col_strobe = 8'hFF;
    tick(2);
    n_total++;
    if (row_out !== 7'h7E) $display("FAIL fire_only: got %h want 7e", row_out);
    else n_pass++;
    send_key(1'b1, 1'b0, 8'h29);
    col_strobe = 8'h7F;
    tick(3);
    n_total++;
    if (row_out !== 7'h76) $display("FAIL fire_space: got %h want 76", row_out);
    else n_pass++;
    send_key(1'b0, 1'b0, 8'h29);
    fire = 2'b00;
    tick(3);
  endtask

  task automatic test_random();
    logic [8:0] k;
    logic [6:0] e;
    logic       mk;
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(9) < 8) begin
        k = kcode[$urandom_range(kcode.size() - 1)];
      end else begin
        do k = 9'($urandom); while (find_key(k) >= 0 || k == 9'h058);
      end
      mk = ($urandom_range(2) != 0);
      send_key(mk, k[8], k[7:0]);
      tick(3);
      col_strobe = 8'($urandom);
      if ($urandom_range(3) == 0) col_strobe = ($urandom_range(1) == 0) ? 8'h00 : 8'hFF;
      fire = 2'($urandom);
`ifndef KEYMATRIX_DRAGON_EN
      dragon = 1'($urandom);
`endif
      tick(2);
      e = exp_row(col_strobe, fire, 1'b0);
      n_total++;
      if (row_out !== e)
        $display("FAIL rand_%0d: key %h col %h fire %b got %h want %h",
                 it, k, col_strobe, fire, row_out, e);
      else n_pass++;
    end
    fire = 2'b00;
    dragon = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    col_strobe = 8'h00;
    send_key(1'b1, 1'b0, 8'h5A);
    tick(3);
    send_key(1'b1, 1'b0, 8'h58);
    tick(7);
    reset = 1'b0;
    tog = 1'b0;
    ps2_key = '0;
    clear_model();
    #1;
    n_total++;
    if (row_out !== 7'h7F) $display("FAIL rstmid_row: got %h want 7f", row_out);
    else n_pass++;
    n_total++;
    if (caps_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", caps_busy);
    else n_pass++;
    tick(2);
    reset = 1'b1;
    tick(20);
    n_total++;
    if (row_out !== 7'h7F) $display("FAIL rstmid_after_row: got %h want 7f", row_out);
    else n_pass++;
    n_total++;
    if (caps_busy !== 1'b0) $display("FAIL rstmid_after_busy: got %b want 0", caps_busy);
    else n_pass++;
  endtask

  task automatic test_dragon();
    col_strobe = 8'hFD;
    send_key(1'b1, 1'b0, 8'h1C);
    tick(3);
    n_total++;
    if (row_out !== 7'h7E) $display("FAIL drg_a_held: got %h want 7e", row_out);
    else n_pass++;
    dragon = 1'b1;
    tick(4);
`ifdef KEYMATRIX_DRAGON_EN
    clear_model();
    n_total++;
    if (row_out !== exp_row(8'hFD, 2'b00, 1'b1))
      $display("FAIL drg_clear: got %h want 7f", row_out);
    else n_pass++;
`else
    n_total++;
    if (row_out !== exp_row(8'hFD, 2'b00, 1'b0))
      $display("FAIL drg_ignored: got %h want 7e", row_out);
    else n_pass++;
`endif
    dragon = 1'b0;
    send_key(1'b0, 1'b0, 8'h1C);
    tick(4);
  endtask

  initial begin
    build_table();
    test_reset();
    test_key_a();
    test_up_arrow();
    test_caps();
    test_fire();
    test_random();
    test_reset_mid();
    test_dragon();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
